// File: rtl/snail_trace_mon.sv
// Trace monitor: captures in-window CPU RAM writes into a timestamped FIFO
// and stops on halt opcode (after a hold window) or on a cycle timeout.
module snail_trace_mon #(
    parameter int unsigned AW         = 8,
    parameter int unsigned DW         = 8,
    parameter int unsigned CW         = 16,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned WIN_BASE   = 0,
    parameter int unsigned WIN_SIZE   = 32,
    parameter logic [3:0]  HLT_OP     = 4'h0,
    parameter int unsigned HALT_DELAY = 1,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_wdat,
    input  logic          ram_wr_,
    input  logic [3:0]    ins,
    output logic          trc_valid,
    input  logic          trc_ready,
    output logic [AW-1:0] trc_addr,
    output logic [DW-1:0] trc_data,
    output logic [CW-1:0] trc_cycle,
    output logic [CW-1:0] cyc_cnt,
    output logic [1:0]    state,
    output logic          done,
    output logic          timed_out,
    output logic          overflow,
    output logic [7:0]    drop_cnt
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned RW = AW + DW + CW;

    // Window bounds carry one extra bit so WIN_BASE+WIN_SIZE == 2^AW still fits.
    localparam logic [AW:0]   WinLo       = (AW+1)'(WIN_BASE);
    localparam logic [AW:0]   WinHi       = (AW+1)'(WIN_BASE + WIN_SIZE);
    localparam logic [CW-1:0] TimeoutLast = CW'(TIMEOUT - 1);
    localparam logic [PW:0]   FullCount   = (PW+1)'(DEPTH);
    localparam logic [7:0]    HoldInit    = 8'(HALT_DELAY);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StHold  = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    hold_q, hold_d;
    logic          timed_out_q, timed_out_d;
    logic [CW-1:0] cyc_q;
    logic          overflow_q;
    logic [7:0]    drop_q;

    logic [RW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;

    logic          in_window, active, capture;
    logic          fifo_full, fifo_empty;
    logic          push, pop, drop;
    logic [RW-1:0] head;

    always_comb begin
        in_window  = ({1'b0, ram_addr} >= WinLo) && ({1'b0, ram_addr} < WinHi);
        active     = (state_q == StRun) || (state_q == StHold);
        capture    = active && !ram_wr_ && in_window;
        fifo_full  = (count_q == FullCount);
        fifo_empty = (count_q == '0);
        pop        = !fifo_empty && trc_ready;
        // A full FIFO still accepts a record when the head leaves in the same cycle.
        push       = capture && (!fifo_full || pop);
        drop       = capture && fifo_full && !pop;
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        timed_out_d = timed_out_q;
        unique case (state_q)
            StRun: begin
                if (ins == HLT_OP) begin
                    state_d = StHold;
                    hold_d  = HoldInit;
                end else if ((TIMEOUT != 0) && (cyc_q == TimeoutLast)) begin
                    state_d     = StDrain;
                    timed_out_d = 1'b1;
                end
            end
            StHold: begin
                if (hold_q == 8'd0) begin
                    state_d = StDrain;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            StDrain: begin
                if (fifo_empty) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StDone;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            hold_q      <= 8'd0;
            timed_out_q <= 1'b0;
            cyc_q       <= '0;
            overflow_q  <= 1'b0;
            drop_q      <= 8'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            timed_out_q <= timed_out_d;
            if ((state_q != StDone) && (cyc_q != '1)) begin
                cyc_q <= cyc_q + CW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != 8'hff) begin
                    drop_q <= drop_q + 8'd1;
                end
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr_q] <= {ram_addr, ram_wdat, cyc_q};
        end
    end

    always_comb begin
        head      = mem[rd_ptr_q];
        trc_valid = !fifo_empty;
        trc_addr  = trc_valid ? head[RW-1 -: AW]    : '0;
        trc_data  = trc_valid ? head[CW+DW-1 -: DW] : '0;
        trc_cycle = trc_valid ? head[CW-1:0]        : '0;
        cyc_cnt   = cyc_q;
        state     = state_q;
        done      = (state_q == StDone);
        timed_out = timed_out_q;
        overflow  = overflow_q;
        drop_cnt  = drop_q;
    end

endmodule

// File: tb/tb_snail_trace_mon.sv
// Directed bench: u_a (DEPTH=4, no timeout) covers capture/FIFO/halt/reset,
// u_b (TIMEOUT=20) covers the forced stop.
module tb_snail_trace_mon;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ram_addr;
    logic [7:0]  ram_wdat;
    logic        ram_wr_;
    logic [3:0]  ins;
    logic        trc_ready;

    logic        a_valid, a_done, a_to, a_ovf;
    logic [7:0]  a_addr, a_data, a_drop;
    logic [15:0] a_tcyc, a_cyc;
    logic [1:0]  a_state;

    logic        b_valid, b_done, b_to, b_ovf;
    logic [7:0]  b_addr, b_data, b_drop;
    logic [15:0] b_tcyc, b_cyc;
    logic [1:0]  b_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snail_trace_mon #(.DEPTH(4), .TIMEOUT(0)) u_a (
        .clk(clk), .rst(rst), .ram_addr(ram_addr), .ram_wdat(ram_wdat), .ram_wr_(ram_wr_),
        .ins(ins), .trc_valid(a_valid), .trc_ready(trc_ready), .trc_addr(a_addr),
        .trc_data(a_data), .trc_cycle(a_tcyc), .cyc_cnt(a_cyc), .state(a_state),
        .done(a_done), .timed_out(a_to), .overflow(a_ovf), .drop_cnt(a_drop)
    );

    snail_trace_mon #(.TIMEOUT(20)) u_b (
        .clk(clk), .rst(rst), .ram_addr(ram_addr), .ram_wdat(ram_wdat), .ram_wr_(ram_wr_),
        .ins(ins), .trc_valid(b_valid), .trc_ready(trc_ready), .trc_addr(b_addr),
        .trc_data(b_data), .trc_cycle(b_tcyc), .cyc_cnt(b_cyc), .state(b_state),
        .done(b_done), .timed_out(b_to), .overflow(b_ovf), .drop_cnt(b_drop)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        ram_addr = a;
        ram_wdat = d;
        ram_wr_  = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        ram_addr  = 8'd0;
        ram_wdat  = 8'd0;
        ram_wr_   = 1'b1;
        ins       = 4'h1;
        trc_ready = 1'b0;
        do_reset();

        check("rst_valid",   32'(a_valid), 0);
        check("rst_cyc",     32'(a_cyc), 0);
        check("rst_state",   32'(a_state), 0);
        check("rst_done",    32'(a_done), 0);
        check("rst_drop",    32'(a_drop), 0);
        check("rst_ovf",     32'(a_ovf), 0);
        check("rst_to",      32'(a_to), 0);
        check("rst_addr",    32'(a_addr), 0);

        // Timeout on u_b: DRAIN at cycle 20, then DONE with frozen counter.
        repeat (19) step();
        check("to_run19",    32'(b_state), 0);
        check("to_cyc19",    32'(b_cyc), 19);
        step();
        check("to_drain",    32'(b_state), 2);
        check("to_flag",     32'(b_to), 1);
        check("to_cyc20",    32'(b_cyc), 20);
        step();
        check("to_done",     32'(b_state), 3);
        check("to_done_o",   32'(b_done), 1);
        repeat (3) step();
        check("to_frozen",   32'(b_cyc), 21);
        check("a_no_to",     32'(a_state), 0);

        // Basic capture: 'H' to addr 3 at cycle 5, addr 40 outside window.
        do_reset();
        trc_ready = 1'b1;
        repeat (5) step();
        wr(8'd3, 8'h48);
        step();
        check("cap_valid",   32'(a_valid), 1);
        check("cap_addr",    32'(a_addr), 3);
        check("cap_data",    32'(a_data), 32'h48);
        check("cap_cycle",   32'(a_tcyc), 5);
        wr(8'd40, 8'h69);
        step();
        check("out_win",     32'(a_valid), 0);
        check("out_drop",    32'(a_drop), 0);
        wr(8'd31, 8'h31);
        step();
        check("edge31_v",    32'(a_valid), 1);
        check("edge31_a",    32'(a_addr), 31);
        check("edge31_c",    32'(a_tcyc), 7);
        wr(8'd32, 8'h32);
        step();
        ram_wr_ = 1'b1;
        check("edge32_v",    32'(a_valid), 0);

        // Overflow with DEPTH=4, then full push+pop, then ordered drain.
        do_reset();
        trc_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr(8'(10 + i), 8'(8'hA0 + i));
            step();
        end
        ram_wr_ = 1'b1;
        check("ovf_valid",   32'(a_valid), 1);
        check("ovf_drop",    32'(a_drop), 2);
        check("ovf_flag",    32'(a_ovf), 1);
        check("ovf_head",    32'(a_addr), 10);
        step();
        check("stall_head",  32'(a_addr), 10);
        check("stall_cyc",   32'(a_tcyc), 0);
        wr(8'd20, 8'hB0);
        trc_ready = 1'b1;
        step();
        ram_wr_ = 1'b1;
        check("pp_drop",     32'(a_drop), 2);
        check("pp_head_a",   32'(a_addr), 11);
        check("pp_head_d",   32'(a_data), 32'hA1);
        check("pp_head_c",   32'(a_tcyc), 1);
        step();
        check("ord_12",      32'(a_addr), 12);
        step();
        check("ord_13",      32'(a_addr), 13);
        step();
        check("ord_20_a",    32'(a_addr), 20);
        check("ord_20_d",    32'(a_data), 32'hB0);
        check("ord_20_c",    32'(a_tcyc), 7);
        step();
        check("ord_empty",   32'(a_valid), 0);

        // Halt at cycle 10, write at cycle 11 captured during HOLD.
        do_reset();
        trc_ready = 1'b0;
        repeat (10) step();
        ins = 4'h0;
        step();
        ins = 4'h1;
        check("hlt_hold1",   32'(a_state), 1);
        wr(8'd5, 8'h55);
        step();
        ram_wr_ = 1'b1;
        check("hlt_hold2",   32'(a_state), 1);
        check("hlt_cap_v",   32'(a_valid), 1);
        check("hlt_cap_c",   32'(a_tcyc), 11);
        step();
        check("hlt_drain",   32'(a_state), 2);
        wr(8'd6, 8'h66);
        step();
        ram_wr_ = 1'b1;
        check("drn_nocap",   32'(a_drop), 0);
        check("drn_head",    32'(a_addr), 5);
        trc_ready = 1'b1;
        step();
        check("drn_popped",  32'(a_valid), 0);
        check("drn_notdone", 32'(a_done), 0);
        step();
        check("hlt_done_s",  32'(a_state), 3);
        check("hlt_done",    32'(a_done), 1);
        check("hlt_cyc",     32'(a_cyc), 16);
        ins = 4'h0;
        repeat (2) step();
        ins = 4'h1;
        check("done_stays",  32'(a_state), 3);
        check("done_frozen", 32'(a_cyc), 16);

        // Reset during DRAIN with three records queued.
        do_reset();
        trc_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            wr(8'(i), 8'(i));
            step();
        end
        ram_wr_ = 1'b1;
        ins = 4'h0;
        step();
        ins = 4'h1;
        step();
        step();
        check("pre_drain",   32'(a_state), 2);
        check("pre_valid",   32'(a_valid), 1);
        rst = 1'b1;
        wr(8'd4, 8'h44);
        ins = 4'h0;
        step();
        rst = 1'b0;
        ram_wr_ = 1'b1;
        ins = 4'h1;
        check("mid_valid",   32'(a_valid), 0);
        check("mid_state",   32'(a_state), 0);
        check("mid_cyc",     32'(a_cyc), 0);
        check("mid_addr",    32'(a_addr), 0);
        check("mid_ovf",     32'(a_ovf), 0);
        step();
        check("post_valid",  32'(a_valid), 0);
        check("post_cyc",    32'(a_cyc), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snail_trace_mon.md
SNAIL_TRACE_MON -- requirements
Module: snail_trace_mon

Interface
REQ-001 Parameter AW, 8, RAM address width.
REQ-002 Parameter DW, 8, RAM data width.
REQ-003 Parameter CW, 16, cycle-counter and timestamp width.
REQ-004 Parameter DEPTH, 16, trace FIFO entries; power of two, >=2.
REQ-005 Parameter WIN_BASE, 0, first RAM address traced.
REQ-006 Parameter WIN_SIZE, 32, number of traced addresses; WIN_BASE+WIN_SIZE <= 2^AW.
REQ-007 Parameter HLT_OP, 4'h0, opcode value meaning halt.
REQ-008 Parameter HALT_DELAY, 1, cycles captured after halt seen; range 0..255.
REQ-009 Parameter TIMEOUT, 1000, cycle limit before forced stop; 0 disables.
REQ-010 clk  in  1  single clock; all logic rising-edge.
REQ-011 rst  in  1  reset; synchronous, active-high.
REQ-012 ram_addr  in  AW  CPU RAM address.
REQ-013 ram_wdat  in  DW  CPU RAM write data.
REQ-014 ram_wr_  in  1  CPU RAM write strobe, active-low.
REQ-015 ins  in  4  opcode field of current instruction word.
REQ-016 trc_valid  out  1  trace record available.
REQ-017 trc_ready  in  1  consumer accepts record.
REQ-018 trc_addr  out  AW  written address of head record.
REQ-019 trc_data  out  DW  written data of head record.
REQ-020 trc_cycle  out  CW  cycle stamp of head record.
REQ-021 cyc_cnt  out  CW  cycles since reset release.
REQ-022 state  out  2  0 RUN, 1 HOLD, 2 DRAIN, 3 DONE.
REQ-023 done  out  1  monitoring finished, FIFO empty.
REQ-024 timed_out  out  1  sticky: stop caused by TIMEOUT.
REQ-025 overflow  out  1  sticky: at least one record dropped.
REQ-026 drop_cnt  out  8  dropped records, saturates at 255.

Function
REQ-027 Capture condition: state RUN or HOLD, ram_wr_==0, WIN_BASE <= ram_addr < WIN_BASE+WIN_SIZE; record {ram_addr, ram_wdat, cyc_cnt} pushed at that edge.
REQ-028 Writes outside window, or in DRAIN/DONE, are ignored and not counted as drops.
REQ-029 cyc_cnt increments each cycle in RUN/HOLD/DRAIN, freezes in DONE, saturates at 2^CW-1.
REQ-030 FIFO is first-in-first-out; trc_valid=1 iff FIFO non-empty; head fields valid only when trc_valid=1.
REQ-031 Pop occurs on edge with trc_valid && trc_ready; head fields SHALL remain stable while trc_valid && !trc_ready.
REQ-032 Read latency: record pushed at edge N is visible on trc_* after edge N when FIFO was empty (no extra stage).
REQ-033 Full FIFO with capture and no pop: record dropped, drop_cnt+1 (saturating), overflow set.
REQ-034 Full FIFO with capture and simultaneous pop: both occur, no drop.
REQ-035 Empty FIFO with simultaneous capture: push only; pop impossible as trc_valid=0.
REQ-036 Pointers wrap modulo DEPTH; occupancy counter distinguishes full from empty.
REQ-037 RUN -> HOLD when ins==HLT_OP sampled at an edge; hold counter loaded with HALT_DELAY.
REQ-038 HOLD decrements counter each cycle; -> DRAIN when counter is 0 (HALT_DELAY=0: one HOLD cycle then DRAIN).
REQ-039 RUN -> DRAIN with timed_out=1 when TIMEOUT!=0 and cyc_cnt reaches TIMEOUT-1; halt in same cycle takes priority (no timeout).
REQ-040 DRAIN -> DONE when FIFO empty; done=1 only in DONE.
REQ-041 DONE is terminal until rst; ins ignored outside RUN.

Reset
REQ-042 rst=1 at an edge: state RUN, FIFO emptied, trc_valid 0, trc_addr/trc_data/trc_cycle 0, cyc_cnt 0, done 0, timed_out 0, overflow 0, drop_cnt 0, hold counter 0.
REQ-043 rst takes priority over every event in the same cycle, including mid-HOLD/DRAIN; in-flight records discarded.

Verification
REQ-044 Defaults; writes 'H' to addr 3 at cycle 5, 'i' to addr 40 at cycle 6, trc_ready=1 -> one record {3,8'h48,5}; addr 40 ignored; drop_cnt 0.
REQ-045 DEPTH=4, trc_ready=0, six in-window writes -> 4 records held, drop_cnt 2, overflow 1; then ready=1 -> records emerge in original order.
REQ-046 FIFO full, write and pop same cycle -> occupancy stays 4, drop_cnt unchanged.
REQ-047 ins=HLT_OP at cycle 10, HALT_DELAY=1, write at cycle 11 -> write captured; state HOLD then DRAIN; done=1 after last pop; cyc_cnt frozen.
REQ-048 TIMEOUT=20, no halt -> state DRAIN at cycle 20, timed_out 1, then DONE once empty.
REQ-049 rst asserted during DRAIN with 3 records queued -> next cycle trc_valid 0, state RUN, all counters/flags 0.
